// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// RISC-V results for divide-by-zero and signed overflow, single-cycle o_valid pulse.
`ifndef _REG_DATA_WIDTH_
`define _REG_DATA_WIDTH_ 32
`endif

module seq_divider #(
  parameter int N     = `_REG_DATA_WIDTH_,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_valid,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t           state_reg;
  logic [N-1:0]     rem_reg;
  logic [N-1:0]     quo_reg;
  logic [N-1:0]     dvsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             busy_reg;
  logic             valid_reg;
  logic             dbz_reg;
  logic [N-1:0]     quotient_reg;
  logic [N-1:0]     remainder_reg;

  // Operand conditioning for the accept cycle; the sign flags already fold in i_signed.
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_abs;
  logic [N-1:0] b_abs;
  logic         div_zero;
  logic         sgn_ovf;

  assign a_neg    = i_signed & i_dividend[N-1];
  assign b_neg    = i_signed & i_divisor[N-1];
  assign a_abs    = a_neg ? -i_dividend : i_dividend;
  assign b_abs    = b_neg ? -i_divisor : i_divisor;
  assign div_zero = (i_divisor == '0);
  assign sgn_ovf  = i_signed && (i_dividend == MIN_NEG) && (i_divisor == '1);

  // One restoring step: (N+1)-bit trial subtract, carry-out set means no borrow.
  logic [N:0] rem_sh;
  logic [N:0] diff;
  logic [N:0] rem_next;
  logic       carry;
  logic       rem_top_unused;

  assign rem_sh         = {rem_reg, quo_reg[N-1]};
  assign {carry, diff}  = {1'b0, rem_sh} + {1'b0, ~{1'b0, dvsr_reg}} + (N+2)'(1);
  assign rem_next       = carry ? diff : rem_sh;
  // The partial remainder is always below the divisor, so bit N is always zero here.
  assign rem_top_unused = rem_next[N];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvsr_reg      <= '0;
      cnt_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          if (i_start) begin
            busy_reg  <= 1'b1;
            q_neg_reg <= a_neg ^ b_neg;
            r_neg_reg <= a_neg;
            dvsr_reg  <= b_abs;
            rem_reg   <= '0;
            quo_reg   <= a_abs;
            cnt_reg   <= CNT_W'(N);
            if (div_zero) begin
              quotient_reg  <= '1;
              remainder_reg <= i_dividend;
              dbz_reg       <= 1'b1;
              valid_reg     <= 1'b1;
              state_reg     <= DONE;
            end else if (sgn_ovf) begin
              quotient_reg  <= MIN_NEG;
              remainder_reg <= '0;
              dbz_reg       <= 1'b0;
              valid_reg     <= 1'b1;
              state_reg     <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          rem_reg <= rem_next[N-1:0];
          quo_reg <= {quo_reg[N-2:0], carry};
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          quotient_reg  <= q_neg_reg ? -quo_reg : quo_reg;
          remainder_reg <= r_neg_reg ? -rem_reg : rem_reg;
          dbz_reg       <= 1'b0;
          valid_reg     <= 1'b1;
          state_reg     <= DONE;
        end

        DONE: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_busy        = busy_reg;
  assign o_valid       = valid_reg;
  assign o_quotient    = quotient_reg;
  assign o_remainder   = remainder_reg;
  assign o_div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle corner
// sequences, and randomized operands against an arithmetic reference model.
module tb_seq_divider;

  localparam int N = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_signed;
  logic [N-1:0]  i_dividend;
  logic [N-1:0]  i_divisor;
  logic          o_busy;
  logic          o_valid;
  logic [N-1:0]  o_quotient;
  logic [N-1:0]  o_remainder;
  logic          o_div_by_zero;

  seq_divider #(.N(N)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_signed      (i_signed),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_valid       (o_valid),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V division rules expressed with plain integer arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dbz, output int lat);
    int sa;
    int sb;
    sa  = a;
    sb  = b;
    dbz = 1'b0;
    lat = N + 2;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Assumes the caller is 1 time unit after a clock edge with the DUT idle.
  // inject_at > 0 raises i_start (with a divide-by-zero pair) during that result cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inject_at,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz,
                        output int lat, output int busy_cycles);
    i_dividend = a; i_divisor = b; i_signed = s; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_dividend = $urandom; i_divisor = $urandom; i_signed = 1'($urandom);
    lat = 0; busy_cycles = 0; q = '0; r = '0; dbz = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c == inject_at) begin
        i_start = 1'b1; i_dividend = 32'h0000_0005; i_divisor = 32'd0; i_signed = 1'b0;
      end else begin
        i_start = 1'b0;
      end
      if (o_busy) busy_cycles++;
      if (o_valid) begin
        lat = c; q = o_quotient; r = o_remainder; dbz = o_div_by_zero;
        break;
      end
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [31:0] q_exp, input logic [31:0] r_exp,
                               input logic dbz_exp, input int lat_exp, input int inject_at);
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          busy_cycles;
    do_div(a, b, s, inject_at, q, r, dbz, lat, busy_cycles);
    $display("%s: a=0x%08h b=0x%08h signed=%0d -> q=0x%08h r=0x%08h dbz=%0d lat=%0d busy=%0d",
             tag, a, b, s, q, r, dbz, lat, busy_cycles);
    check({tag, ".quotient"}, q, q_exp);
    check({tag, ".remainder"}, r, r_exp);
    check({tag, ".div_by_zero"}, 32'(dbz), 32'(dbz_exp));
    check({tag, ".latency"}, lat, lat_exp);
    check({tag, ".busy_cycles"}, busy_cycles, lat_exp);
    check({tag, ".valid_after"}, 32'(o_valid), 32'd0);
    check({tag, ".busy_after"}, 32'(o_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 32'(o_busy), 32'd0);
    check({tag, ".valid"}, 32'(o_valid), 32'd0);
    check({tag, ".quotient"}, o_quotient, 32'd0);
    check({tag, ".remainder"}, o_remainder, 32'd0);
    check({tag, ".div_by_zero"}, 32'(o_div_by_zero), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q_exp;
    logic [31:0] r_exp;
    logic        dbz_exp;
    int          lat_exp;
    logic        seen_valid;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34};
    vecs[2]  = '{32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0, 34};
    vecs[3]  = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1};
    vecs[4]  = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1};
    vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1};
    vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 34};
    vecs[7]  = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0, 34};
    vecs[8]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 34};
    vecs[9]  = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0, 34};
    vecs[10] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 34};
    vecs[11] = '{32'hFFFF_FFFF,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1};
    vecs[12] = '{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          1'b0, 34};

    i_rst = 1'b1; i_start = 1'b0; i_signed = 1'b0; i_dividend = '0; i_divisor = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                    vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, 0);
    end

    // Start pulse mid-operation must be ignored.
    run_and_check("start_busy", 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0, 34, 10);
    // Start pulse coinciding with o_valid must be ignored.
    run_and_check("start_valid", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 34);

    repeat (5) @(posedge i_clk);
    #1;
    check("hold.quotient", o_quotient, 32'd14);
    check("hold.remainder", o_remainder, 32'd2);
    check("hold.busy", 32'(o_busy), 32'd0);

    // Reset in cycle 15 of a division discards it.
    i_dividend = 32'hFFFF_FFFF; i_divisor = 32'd3; i_signed = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (14) @(posedge i_clk);
    #1;
    check("midop.busy_before_rst", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_all_zero("midop_rst");
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_valid || o_busy) seen_valid = 1'b1;
    end
    check("midop.no_valid", 32'(seen_valid), 32'd0);
    run_and_check("after_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, 0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3:    b = $urandom_range(1, 15);
        4:       b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, s, q_exp, r_exp, dbz_exp, lat_exp);
      run_and_check($sformatf("rand%0d", i), a, b, s, q_exp, r_exp, dbz_exp, lat_exp, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
